// File: rtl/sub_operand_sequencer.sv
// Two-byte operand sequencer for an external subtraction unit: loads A then B,
// captures the difference and flags, and holds them until consumed.
// Optional feature: define SUB_SEQ_SAT_EN to clamp underflowing results to 0x00.
module sub_operand_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] A,
    output logic [7:0] B,
    input  logic [7:0] SUB_Out,
    input  logic       CarryOut,
    output logic [7:0] res,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       flag_zero,
    output logic       flag_borrow,
    output logic       flag_carry
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [7:0] r_res;
    logic       r_zero;
    logic       r_borrow;
    logic       r_carry;

    logic       w_din_ready;
    logic       w_xfer;
    logic       w_borrow;
    logic [7:0] w_res;

    assign w_din_ready = (r_state == LOAD_A) || (r_state == LOAD_B);
    assign w_xfer      = din_valid && w_din_ready;
    assign w_borrow    = (r_a < r_b);

`ifdef SUB_SEQ_SAT_EN
    // Underflow clamps to zero; borrow still reports the true comparison.
    assign w_res = w_borrow ? 8'h00 : SUB_Out;
`else
    assign w_res = SUB_Out;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LOAD_A;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LOAD_A:  if (w_xfer) w_next = LOAD_B;
            LOAD_B:  if (w_xfer) w_next = EXEC;
            EXEC:    w_next = HOLD;
            HOLD:    if (res_ready) w_next = LOAD_A;
            default: w_next = LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_zero   <= 1'b0;
            r_borrow <= 1'b0;
            r_carry  <= 1'b0;
        end else begin
            case (r_state)
                LOAD_A: if (w_xfer) r_a <= din;
                LOAD_B: if (w_xfer) r_b <= din;
                EXEC: begin
                    r_res    <= w_res;
                    r_zero   <= (w_res == 8'h00);
                    r_borrow <= w_borrow;
                    r_carry  <= CarryOut;
                end
                default: ;
            endcase
        end
    end

    assign din_ready   = w_din_ready;
    assign A           = r_a;
    assign B           = r_b;
    assign res         = r_res;
    assign res_valid   = (r_state == HOLD);
    assign flag_zero   = r_zero;
    assign flag_borrow = r_borrow;
    assign flag_carry  = r_carry;

endmodule

// File: tb/tb_sub_operand_sequencer.sv
// Scoreboard bench for sub_operand_sequencer with a behavioural subtraction unit.
// Honours SUB_SEQ_SAT_EN when choosing expected results.
module tb_sub_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] SUB_Out;
    logic       CarryOut;
    logic [7:0] res;
    logic       res_valid;
    logic       res_ready;
    logic       flag_zero;
    logic       flag_borrow;
    logic       flag_carry;

    typedef struct packed {
        logic [7:0] r;
        logic       z;
        logic       b;
        logic       c;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Subtraction unit: carry set when no borrow occurs.
    assign SUB_Out  = A - B;
    assign CarryOut = (A >= B);

    sub_operand_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .A           (A),
        .B           (B),
        .SUB_Out     (SUB_Out),
        .CarryOut    (CarryOut),
        .res         (res),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .flag_zero   (flag_zero),
        .flag_borrow (flag_borrow),
        .flag_carry  (flag_carry)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted result is checked against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(res), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res",         32'(res),         32'(e.r));
                check("flag_zero",   32'(flag_zero),   32'(e.z));
                check("flag_borrow", 32'(flag_borrow), 32'(e.b));
                check("flag_carry",  32'(flag_carry),  32'(e.c));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit done = 0;
        din       = b;
        din_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (din_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) check("din_ready_timeout", 32'd0, 32'd1);
        din_valid = 1'b0;
    endtask

    // Full transaction with res_ready held high; also checks latency and one-cycle valid.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input exp_t e);
        res_ready = 1'b1;
        sb.push_back(e);
        send_byte(a);
        check("a_loaded", 32'(A), 32'(a));
        send_byte(b);
        check("exec_valid_low", 32'(res_valid), 32'd0);
        check("exec_ready_low", 32'(din_ready), 32'd0);
        @(posedge clk); #1;
        check("hold_valid_high", 32'(res_valid), 32'd1);
        @(posedge clk); #1;
        check("valid_fall", 32'(res_valid), 32'd0);
        check("ready_after", 32'(din_ready), 32'd1);
    endtask

    function automatic exp_t mk(input logic [7:0] r, input logic z, input logic b, input logic c);
        exp_t e;
        e.r = r; e.z = z; e.b = b; e.c = c;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0; din = '0; din_valid = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_A",         32'(A),         32'd0);
        check("rst_B",         32'(B),         32'd0);
        check("rst_res",       32'(res),       32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_flags",     32'({flag_zero, flag_borrow, flag_carry}), 32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd1);

        run_op(8'h50, 8'h30, mk(8'h20, 1'b0, 1'b0, 1'b1));
`ifdef SUB_SEQ_SAT_EN
        run_op(8'h10, 8'h20, mk(8'h00, 1'b1, 1'b1, 1'b0));
        run_op(8'h00, 8'h01, mk(8'h00, 1'b1, 1'b1, 1'b0));
`else
        run_op(8'h10, 8'h20, mk(8'hF0, 1'b0, 1'b1, 1'b0));
        run_op(8'h00, 8'h01, mk(8'hFF, 1'b0, 1'b1, 1'b0));
`endif
        run_op(8'h42, 8'h42, mk(8'h00, 1'b1, 1'b0, 1'b1));
        run_op(8'hFF, 8'h00, mk(8'hFF, 1'b0, 1'b0, 1'b1));

        // Stall in HOLD with a byte offered that must not be consumed.
        res_ready = 1'b0;
        e = mk(8'hC0, 1'b0, 1'b0, 1'b1);
        sb.push_back(e);
        send_byte(8'hC8);
        send_byte(8'h08);
        @(posedge clk); #1;
        din = 8'h99; din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(res_valid), 32'd1);
            check("stall_ready", 32'(din_ready), 32'd0);
            check("stall_res",   32'(res),       32'hC0);
            check("stall_flags", 32'({flag_zero, flag_borrow, flag_carry}), 32'b001);
            check("stall_A",     32'(A),         32'hC8);
            check("stall_B",     32'(B),         32'h08);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        sb.push_back(mk(8'h90, 1'b0, 1'b0, 1'b1));
        send_byte(8'h99);
        check("held_byte_as_A", 32'(A), 32'h99);
        send_byte(8'h09);
        repeat (3) @(posedge clk);
        #1;

        // Reset between A and B discards the partial operand.
        send_byte(8'h7F);
        check("midload_A", 32'(A), 32'h7F);
        rst_n = 1'b0; din = 8'h05; din_valid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; din_valid = 1'b0;
        check("midrst_A",         32'(A),         32'd0);
        check("midrst_B",         32'(B),         32'd0);
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        check("midrst_din_ready", 32'(din_ready), 32'd1);
        check("midrst_flags",     32'({flag_zero, flag_borrow, flag_carry}), 32'd0);
        run_op(8'h05, 8'h03, mk(8'h02, 1'b0, 1'b0, 1'b1));

        // Reset while holding a result drops it.
        res_ready = 1'b0;
        send_byte(8'h33);
        send_byte(8'h11);
        @(posedge clk); #1;
        check("pre_rst_hold", 32'(res_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("holdrst_valid", 32'(res_valid), 32'd0);
        check("holdrst_res",   32'(res),       32'd0);
        check("holdrst_A",     32'(A),         32'd0);
        check("holdrst_ready", 32'(din_ready), 32'd1);
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
